// File: rtl/alu_decode_stage.sv
// RV32I decode/issue stage: decodes one instruction word per handshake into the ALU
// op, operand selects and immediate, held in a single registered slot toward execute.
module alu_decode_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_sel,
  output logic            out_a_sel,
  output logic            out_b_sel,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_reg_write,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd15;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic            valid_q, valid_d;
  logic [3:0]      alu_sel_q, alu_sel_d;
  logic            a_sel_q, a_sel_d;
  logic            b_sel_q, b_sel_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [4:0]      rd_q, rd_d;
  logic [4:0]      rs1_q, rs1_d;
  logic [4:0]      rs2_q, rs2_d;
  logic            reg_write_q, reg_write_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic [3:0]  f3_op;
  logic [3:0]  dec_alu;
  logic        dec_a, dec_b, dec_rw, dec_ill;
  logic [31:0] dec_imm;
  logic        accept;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u  = {in_inst[31:12], 12'b0};
  assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign imm_sh = {27'b0, in_inst[24:20]};

  // Shared funct3 map for register and immediate ALU forms (alternate ops patched below).
  always_comb begin
    case (funct3)
      3'b000:  f3_op = OP_ADD;
      3'b001:  f3_op = OP_SLL;
      3'b010:  f3_op = OP_SLT;
      3'b011:  f3_op = OP_SLTU;
      3'b100:  f3_op = OP_XOR;
      3'b101:  f3_op = OP_SRL;
      3'b110:  f3_op = OP_OR;
      default: f3_op = OP_AND;
    endcase
  end

  always_comb begin
    dec_alu = OP_ADD;
    dec_a   = 1'b0;
    dec_b   = 1'b1;
    dec_imm = 32'b0;
    dec_rw  = 1'b1;
    dec_ill = 1'b0;
    case (opcode)
      OPC_R: begin
        dec_b   = 1'b0;
        dec_alu = f3_op;
        if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      dec_alu = OP_SUB;
          else if (funct3 == 3'b101) dec_alu = OP_SRA;
          else                       dec_ill = 1'b1;
        end else if (funct7 != F7_ZERO) begin
          dec_ill = 1'b1;
        end
      end
      OPC_I: begin
        dec_alu = f3_op;
        dec_imm = imm_i;
        if (funct3 == 3'b001) begin
          dec_imm = imm_sh;
          dec_ill = (funct7 != F7_ZERO);
        end else if (funct3 == 3'b101) begin
          dec_imm = imm_sh;
          if (funct7 == F7_ALT)       dec_alu = OP_SRA;
          else if (funct7 != F7_ZERO) dec_ill = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_alu = OP_PASSB;
        dec_imm = imm_u;
      end
      OPC_AUIPC: begin
        dec_a   = 1'b1;
        dec_imm = imm_u;
      end
      OPC_LOAD:  dec_imm = imm_i;
      OPC_STORE: begin
        dec_imm = imm_s;
        dec_rw  = 1'b0;
      end
      OPC_BRANCH: begin
        dec_b   = 1'b0;
        dec_imm = imm_b;
        dec_rw  = 1'b0;
        case (funct3[2:1])
          2'b00:   dec_alu = OP_SUB;
          2'b10:   dec_alu = OP_SLT;
          2'b11:   dec_alu = OP_SLTU;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec_a   = 1'b1;
        dec_imm = imm_j;
      end
      OPC_JALR: begin
        dec_imm = imm_i;
        dec_ill = (funct3 != 3'b000);
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d     = valid_q;
    alu_sel_d   = alu_sel_q;
    a_sel_d     = a_sel_q;
    b_sel_d     = b_sel_q;
    imm_d       = imm_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    reg_write_d = reg_write_q;
    illegal_d   = illegal_q;
    pc_d        = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d     = 1'b1;
      alu_sel_d   = dec_ill ? OP_ADD : dec_alu;
      a_sel_d     = dec_ill ? 1'b0 : dec_a;
      b_sel_d     = dec_ill ? 1'b0 : dec_b;
      imm_d       = dec_ill ? '0 : dec_imm;
      rd_d        = in_inst[11:7];
      rs1_d       = in_inst[19:15];
      rs2_d       = in_inst[24:20];
      reg_write_d = dec_rw && !dec_ill && (in_inst[11:7] != 5'd0);
      illegal_d   = dec_ill;
      pc_d        = in_pc;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      alu_sel_q   <= OP_ADD;
      a_sel_q     <= 1'b0;
      b_sel_q     <= 1'b0;
      imm_q       <= '0;
      rd_q        <= 5'd0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
      pc_q        <= RESET_PC;
    end else begin
      valid_q     <= valid_d;
      alu_sel_q   <= alu_sel_d;
      a_sel_q     <= a_sel_d;
      b_sel_q     <= b_sel_d;
      imm_q       <= imm_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      reg_write_q <= reg_write_d;
      illegal_q   <= illegal_d;
      pc_q        <= pc_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_alu_sel   = alu_sel_q;
  assign out_a_sel     = a_sel_q;
  assign out_b_sel     = b_sel_q;
  assign out_imm       = imm_q;
  assign out_rd        = rd_q;
  assign out_rs1       = rs1_q;
  assign out_rs2       = rs2_q;
  assign out_reg_write = reg_write_q;
  assign out_illegal   = illegal_q;
  assign out_pc        = pc_q;

endmodule
